// File: rtl/sh4a_operand_stage.sv
// rtl/sh4a_operand_stage.sv - SH-4A operand-fetch stage with banked regfile and busy scoreboard
//
// Reads a 24-entry banked register file for decoded ALU ops, holds the result
// in a one-entry output register, and accepts ALU writebacks. A per-register
// busy bit blocks issue on RAW/WAW hazards.
//
// Optional feature macro: SH4A_OPERAND_BYPASS_EN
//   defined   - a same-cycle writeback is forwarded to the sources and masks
//               the matching busy bit, so a dependent op issues in the wb cycle
//   undefined - no forwarding; dependent ops wait for the cycle after wb
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   decoded op handshake
//   in_op, in_rn, in_rm, in_imm, in_use_imm, in_wb_en   decoded op fields
//   sr_md, sr_rb        bank select inputs (bank1 when both set)
//   out_valid/out_ready ALU handshake
//   out_op, out_src1, out_src2, out_rd, out_wb_en       ALU operands
//   wb_en, wb_rd, wb_data                               ALU writeback
module sh4a_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rm,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic        in_wb_en,
  input  logic        sr_md,
  input  logic        sr_rb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_op,
  output logic [31:0] out_src1,
  output logic [31:0] out_src2,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0] regs [24];
  logic [23:0] busy;

  // Logical R0-R7 map to physical 16-23 when bank1 is active.
  function automatic logic [4:0] phys(input logic [3:0] r, input logic bank1);
    phys = (!r[3] && bank1) ? {2'b10, r[2:0]} : {1'b0, r};
  endfunction

  logic        bank1;
  logic [4:0]  rn_p;
  logic [4:0]  rm_p;
  logic        wb_valid;
  logic [23:0] wb_mask;
  logic [23:0] set_mask;
  logic [23:0] busy_eff;
  logic        rn_busy;
  logic        rm_busy;
  logic        hazard;
  logic        slot_free;
  logic        issue;
  logic [31:0] rn_val;
  logic [31:0] rm_val;

  assign bank1    = sr_md & sr_rb;
  assign rn_p     = phys(in_rn, bank1);
  assign rm_p     = phys(in_rm, bank1);
  // Out-of-range writeback indices are dropped entirely.
  assign wb_valid = wb_en && (wb_rd < 5'd24);
  assign wb_mask  = wb_valid ? (24'd1 << wb_rd) : 24'd0;

`ifdef SH4A_OPERAND_BYPASS_EN
  assign busy_eff = busy & ~wb_mask;
  assign rn_val   = (wb_valid && wb_rd == rn_p) ? wb_data : regs[rn_p];
  assign rm_val   = (wb_valid && wb_rd == rm_p) ? wb_data : regs[rm_p];
`else
  assign busy_eff = busy;
  assign rn_val   = regs[rn_p];
  assign rm_val   = regs[rm_p];
`endif

  assign rn_busy   = busy_eff[rn_p];
  assign rm_busy   = busy_eff[rm_p];
  // The destination is Rn, so the WAW term coincides with the src1 RAW term.
  assign hazard    = rn_busy | (!in_use_imm & rm_busy) | (in_wb_en & rn_busy);
  assign slot_free = !out_valid | out_ready;
  assign in_ready  = slot_free & !hazard;
  assign issue     = in_valid & in_ready;
  assign set_mask  = (issue && in_wb_en) ? (24'd1 << rn_p) : 24'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_src1  <= '0;
      out_src2  <= '0;
      out_rd    <= '0;
      out_wb_en <= 1'b0;
      busy      <= '0;
      for (int i = 0; i < 24; i++) regs[i] <= '0;
    end else begin
      if (wb_valid) regs[wb_rd] <= wb_data;
      // Clear first, then set, so an issue to the same index keeps it busy.
      busy <= (busy & ~wb_mask) | set_mask;
      if (issue) begin
        out_valid <= 1'b1;
        out_op    <= in_op;
        out_src1  <= rn_val;
        out_src2  <= in_use_imm ? in_imm : rm_val;
        out_rd    <= rn_p;
        out_wb_en <= in_wb_en;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
